// File: rtl/wb_fifo_slave_pkg.sv
// Shared definitions for the wb_fifo_slave register block.
//  - register offsets within the 256-byte Wishbone window
//  - STATUS / CTRL bit positions and field widths
//  - offset decoder and byte-select mask helper
package wb_fifo_slave_pkg;

  localparam logic [7:0] OFS_DATA   = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h04;
  localparam logic [7:0] OFS_CTRL   = 8'h08;
  localparam logic [7:0] OFS_IO_OUT = 8'h0C;

  // STATUS bit positions; count occupies [7:0], DEPTH occupies [31:16]
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_UNF   = 11;

  // CTRL bit positions
  localparam int CT_FLUSH   = 0;
  localparam int CT_CLR_OVF = 1;
  localparam int CT_CLR_UNF = 2;
  localparam int CT_THR_LSB = 4;
  localparam int THR_W      = 8;

  localparam int IO_W = 16;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_IO_OUT
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] ofs);
    case (ofs)
      OFS_DATA:   return REG_DATA;
      OFS_STATUS: return REG_STATUS;
      OFS_CTRL:   return REG_CTRL;
      OFS_IO_OUT: return REG_IO_OUT;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo_slave_mem.sv
// Synchronous FIFO built from registers, head word visible combinationally so
// a pop can return it in the same accept cycle.
// Ports:
//  clk, rst          clock, asynchronous active-high reset (pointers/count only)
//  push, pop, flush  requests; push ignored when full, pop ignored when empty,
//                    flush has priority and clears pointers and count
//  din / dout        write data / current head word
//  count             occupancy 0..DEPTH (DEPTH_LOG2+1 bits)
//  full, empty       occupancy flags
module wb_fifo_slave_mem #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  do_push, do_pop;

  assign full    = (count_reg == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // pointers wrap naturally at DEPTH_LOG2 bits
      if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // storage needs no reset: the count gates every read of it
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone slave exposing a word FIFO, status/control registers and a 16-bit
// output port for the user project area.
// Optional feature: define WB_FIFO_IRQ_EN to store the CTRL threshold and
// drive a registered FIFO-level interrupt; otherwise irq is tied low.
// Ports:
//  wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//  wbs_cyc_i/stb_i/we_i Wishbone cycle, strobe, write enable
//  wbs_sel_i            byte selects
//  wbs_adr_i/dat_i      byte address / write data
//  wbs_ack_o/dat_o      single-cycle ack / read data valid with ack
//  io_out, io_oeb       output register and its (always enabled) output enables
//  irq                  FIFO level interrupt
module wb_fifo_slave
  import wb_fifo_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [IO_W-1:0]  io_out,
  output logic [IO_W-1:0]  io_oeb,
  output logic             irq
);

  localparam logic [15:0] DEPTH_W = 16'(1 << DEPTH_LOG2);

  logic                  ack_reg;
  logic [31:0]           dat_o_reg;
  logic [IO_W-1:0]       io_out_reg, io_out_next;
  logic                  ovf_reg, unf_reg;
  logic                  accept, wr_acc, rd_acc;
  reg_sel_e              reg_sel;
  logic [31:0]           rdata;
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic [31:0]           fifo_dout;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  data_wr, data_rd, ctrl_wr, io_wr;

  // ~ack_reg enforces the idle cycle between back-to-back transfers
  assign accept  = wbs_cyc_i & wbs_stb_i & ~ack_reg & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign reg_sel = decode_offset(wbs_adr_i[7:0]);
  assign wr_acc  = accept & wbs_we_i;
  assign rd_acc  = accept & ~wbs_we_i;

  assign data_wr = wr_acc & (reg_sel == REG_DATA) & (|wbs_sel_i);
  assign data_rd = rd_acc & (reg_sel == REG_DATA);
  assign ctrl_wr = wr_acc & (reg_sel == REG_CTRL) & wbs_sel_i[0];
  assign io_wr   = wr_acc & (reg_sel == REG_IO_OUT);

  assign fifo_push  = data_wr;
  assign fifo_pop   = data_rd;
  assign fifo_flush = ctrl_wr & wbs_dat_i[CT_FLUSH];

  wb_fifo_slave_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_mem (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wbs_dat_i),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // byte-masked update of the output register
  for (genvar gi = 0; gi < IO_W/8; gi++) begin : g_io_byte
    assign io_out_next[8*gi +: 8] = (io_wr && wbs_sel_i[gi]) ? wbs_dat_i[8*gi +: 8]
                                                              : io_out_reg[8*gi +: 8];
  end

`ifdef WB_FIFO_IRQ_EN
  logic [THR_W-1:0] thr_reg, thr_next;
  logic             irq_reg;

  // threshold field CTRL[11:4] straddles byte lanes 0 and 1
  always_comb begin
    thr_next = thr_reg;
    if (wr_acc && reg_sel == REG_CTRL) begin
      if (wbs_sel_i[0]) thr_next[3:0] = wbs_dat_i[CT_THR_LSB +: 4];
      if (wbs_sel_i[1]) thr_next[7:4] = wbs_dat_i[CT_THR_LSB+4 +: 4];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      thr_reg <= '0;
      irq_reg <= 1'b0;
    end else begin
      thr_reg <= thr_next;
      // sampled from the registered count, so it trails a count change by one cycle
      irq_reg <= (thr_reg != '0) && (THR_W'(fifo_count) >= thr_reg);
    end
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DATA:   rdata = fifo_empty ? 32'h0 : fifo_dout;
      REG_STATUS: begin
        rdata[7:0]      = 8'(fifo_count);
        rdata[ST_EMPTY] = fifo_empty;
        rdata[ST_FULL]  = fifo_full;
        rdata[ST_OVF]   = ovf_reg;
        rdata[ST_UNF]   = unf_reg;
        rdata[31:16]    = DEPTH_W;
      end
`ifdef WB_FIFO_IRQ_EN
      REG_CTRL:   rdata[CT_THR_LSB +: THR_W] = thr_reg;
`endif
      REG_IO_OUT: rdata[IO_W-1:0] = io_out_reg;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg    <= 1'b0;
      dat_o_reg  <= '0;
      io_out_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      ack_reg    <= accept;
      dat_o_reg  <= rd_acc ? rdata : 32'h0;
      io_out_reg <= io_out_next;
      if (data_wr && fifo_full)
        ovf_reg <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[CT_CLR_OVF])
        ovf_reg <= 1'b0;
      if (data_rd && fifo_empty)
        unf_reg <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[CT_CLR_UNF])
        unf_reg <= 1'b0;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_o_reg;
  assign io_out    = io_out_reg;
  assign io_oeb    = '0;

endmodule

// File: tb/tb_wb_fifo_slave.sv
module tb_wb_fifo_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] io_out, io_oeb;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];    // scoreboard of expected read data
  logic [31:0] fifo_model[$];

  localparam logic [31:0] A_DATA = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_CTRL = 32'h3000_0008;
  localparam logic [31:0] A_IO   = 32'h3000_000C;

  always #5 clk = ~clk;

  wb_fifo_slave dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one bus transfer; returns read data, checks ack arrives and lasts one cycle
  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    logic got_ack;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got_ack = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (ack) begin got_ack = 1'b1; break; end
    end
    rd = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("txn %s adr=%h wdat=%h sel=%h rdat=%h ack=%0d", w ? "WR" : "RD", a, d, s, rd, got_ack);
    if (!got_ack) check("ack_timeout", 32'(got_ack), 32'h1);
    else begin
      @(posedge clk); #1;
      check("ack_width", 32'(ack), 32'h0);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    if (a == A_DATA && s != 4'h0 && fifo_model.size() < 8) fifo_model.push_back(d);
    wb_cycle(1'b1, a, d, s, rd);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    exp_q.push_back(exp);
    wb_cycle(1'b0, a, 32'h0, 4'hF, rd);
    check(tag, rd, exp_q.pop_front());
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = (fifo_model.size() > 0) ? fifo_model.pop_front() : 32'h0;
    wb_read(tag, A_DATA, e);
  endtask

  initial begin
    logic [31:0] v;
    int acks;

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_io_out", 32'(io_out), 32'h0);
    check("io_oeb", 32'(io_oeb), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    wb_read("rst_status", A_STAT, 32'h0008_0100);

    // IO_OUT writes and byte masking
    wb_write(A_IO, 32'h0000_AB60, 4'h3);
    check("io_out_1", 32'(io_out), 32'h0000_AB60);
    wb_write(A_IO, 32'hFFFF_AB61, 4'hF);
    check("io_out_2", 32'(io_out), 32'h0000_AB61);
    wb_write(A_IO, 32'h0000_12FF, 4'h1);
    check("io_out_mask", 32'(io_out), 32'h0000_ABFF);
    wb_read("io_readback", A_IO, 32'h0000_ABFF);

    // reset in the middle of a transfer
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_IO; wdat = 32'h1234; sel = 4'h3;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack), 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_ack", 32'(ack), 32'h0);
    check("midrst_io_out", 32'(io_out), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    wb_read("midrst_status", A_STAT, 32'h0008_0100);

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) wb_write(A_DATA, 32'(i), 4'hF);
    wb_read("status_full", A_STAT, 32'h0008_0208);
    wb_write(A_DATA, 32'h99, 4'hF);
    wb_read("status_ovf", A_STAT, 32'h0008_0608);
    for (int i = 1; i <= 8; i++) pop_check("pop_order");
    wb_read("status_drained", A_STAT, 32'h0008_0500);
    wb_write(A_CTRL, 32'h2, 4'h1);
    wb_read("status_ovf_clr", A_STAT, 32'h0008_0100);

    // underflow and W1C
    pop_check("pop_empty");
    wb_read("status_unf", A_STAT, 32'h0008_0900);
    wb_write(A_CTRL, 32'h4, 4'h1);
    wb_read("status_unf_clr", A_STAT, 32'h0008_0100);
    wb_read("ctrl_low_bits", A_CTRL, 32'h0);

    // pointer wrap with random data
    for (int i = 0; i < 5; i++) wb_write(A_DATA, $urandom, 4'hF);
    for (int i = 0; i < 5; i++) pop_check("pop_wrap");
    for (int i = 0; i < 3; i++) wb_write(A_DATA, $urandom, 4'hF);
    wb_read("status_cnt3", A_STAT, 32'h0008_0003);

    // flush
    wb_write(A_CTRL, 32'h1, 4'h1);
    fifo_model.delete();
    wb_read("status_flush", A_STAT, 32'h0008_0100);
    pop_check("pop_after_flush");
    wb_write(A_CTRL, 32'h4, 4'h1);

    // threshold interrupt
    wb_write(A_CTRL, 32'h30, 4'h3);
`ifdef WB_FIFO_IRQ_EN
    wb_read("ctrl_thr", A_CTRL, 32'h30);
    wb_write(A_DATA, 32'hA1, 4'hF);
    wb_write(A_DATA, 32'hA2, 4'hF);
    check("irq_below", 32'(irq), 32'h0);
    wb_write(A_DATA, 32'hA3, 4'hF);
    check("irq_set", 32'(irq), 32'h1);
    pop_check("pop_irq");
    check("irq_clear", 32'(irq), 32'h0);
`else
    wb_read("ctrl_thr_absent", A_CTRL, 32'h0);
    for (int i = 0; i < 3; i++) wb_write(A_DATA, 32'hA0 + 32'(i), 4'hF);
    check("irq_tied", 32'(irq), 32'h0);
`endif
    wb_write(A_CTRL, 32'h1, 4'h1);
    fifo_model.delete();
    wb_read("status_irq_flush", A_STAT, 32'h0008_0100);

    // out-of-window access gets no ack
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    $display("txn RD adr=30000100 out-of-window acks=%0d", acks);
    check("oow_no_ack", 32'(acks), 32'h0);

    // unmapped in-window offset: ack, read 0, write ignored
    wb_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    wb_read("unmapped_rd", 32'h3000_0010, 32'h0);
    wb_read("unmapped_status", A_STAT, 32'h0008_0100);
    v = 32'(io_out);
    check("unmapped_io", v, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
